uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Parametrised next-generation UART transmitter with configurable data width, parity mode and stop-bit count.
- Adds a valid/ready input handshake and a one-entry holding register, so frames go out back-to-back with no idle gap.
- Baud divider restarts at each frame start, so every start bit is exactly one bit period long.
- Sits between a byte-stream producer (FIFO, command engine) and the serial pin.

Parameters:
- CLK_FRQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s. BAUD_DIV = CLK_FRQ / BAUD_RATE (integer divide).
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- areset_n  in  1  synchronous active-low reset.
- in_valid  in  1  producer has a word on in_data.
- in_data  in  DATA_BITS  word to send, LSB first.
- in_ready  out  1  holding register empty; a transfer occurs on a rising edge with in_valid & in_ready.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  a frame is on the line.
- tx_done  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset: clk and areset_n are as decided above (one clock; reset synchronous, active-low). While areset_n=0 at a clk edge:
  - tx=1, tx_busy=0, tx_done=0, in_ready=1.
  - Hold register cleared, baud counter=0, bit counter=0, state=IDLE.
- Elaboration fatal errors: BAUD_DIV<2, DATA_BITS outside 5..9, PARITY>2, STOP_BITS not 1 or 2.
- Holding register:
  - in_ready = !hold_valid.
  - On accept at edge k: hold_data<=in_data, hold_valid<=1.
  - The FSM drains the holding register when it loads a frame. in_data is never sampled while in_ready=0.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1, tx_busy=0. If hold_valid: load shifter, clear hold_valid, go to START, baud counter<=0. tx is low from edge k+1 (one cycle after the accept edge).
  - START: tx=0 for BAUD_DIV cycles, then DATA.
  - DATA: tx=shifter[0] for BAUD_DIV cycles per bit, LSB first, shift right. After DATA_BITS bits, go to PAR if PARITY!=0, else STOP.
  - PAR: tx = XOR of frame data bits (even), or its inverse (odd), for BAUD_DIV cycles.
  - STOP: tx=1 for STOP_BITS*BAUD_DIV cycles.
  - End of last stop cycle: tx_done pulses for exactly one cycle.
    - If hold_valid, go directly to START (load, clear hold_valid) with zero idle cycles between stop bit and next start bit; tx_busy stays 1.
    - Otherwise go to IDLE, tx_busy<=0.
- tx_busy=1 in every state except IDLE.
- Frame length: BAUD_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, exactly.
- Baud counter: width $clog2(BAUD_DIV). Counts 0..BAUD_DIV-1, wraps; the bit advances on the wrap. Held at 0 in IDLE.
- Simultaneous events:
  - Accept into the hold register in the same cycle the FSM drains it is impossible: in_ready=0 while hold_valid=1. in_ready rises the cycle after the drain.
  - in_valid held high continuously yields gapless frames.
- Reset mid-frame: tx returns to 1 after the reset edge, no tx_done, pending hold word discarded.
- tx is registered, glitch-free.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN).
  - tx_state_e enum.
  - frame_len function returning the bit count of a frame.
- Sub-module uart_baud_gen: parametrised by BAUD_DIV; inputs clk, areset_n, restart; output one-cycle tick. Reusable by the future receiver.

Test Plan:
- CLK_FRQ=1000, BAUD_RATE=100 (BAUD_DIV=10), 8N1, send 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_done pulses once after 100 cycles; tx_busy high for 100 cycles.
- 8E1, send 0x07 -> parity bit 1; 8O1, send 0x07 -> parity bit 0; both frames 110 cycles long.
- 7O2, DATA_BITS=7, send 0x7F -> bits 0,1111111,0,1,1; 110 cycles; single tx_done.
- 8N1, in_valid held with 0x55 then 0xAA -> second start bit begins the cycle after the first stop bit ends; 200 cycles total; two tx_done pulses; in_ready low while the hold register is full.
- 8N1, in_valid=1 with in_ready=0, in_data changed mid-frame -> changed value not transmitted; only the accepted word appears.
- Assert areset_n=0 during data bit 3 with a word pending in the hold register -> tx=1, tx_busy=0, in_ready=1 after the edge; no tx_done; the pending word is never sent; the next 0x3C frame is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the configurable UART
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - valid/ready word handshake into the UART transmitter
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period divider with restart, one-cycle tick on wrap
module uart_baud_gen #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic areset_n,
  input  logic restart,
  output logic tick
);
  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!areset_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign tick = !restart && (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - UART transmitter with holding register and gapless back-to-back frames
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FRQ   = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic         clk,
  input  logic         areset_n,
  uart_tx_cfg_if.slave s,
  output logic         tx,
  output logic         tx_busy,
  output logic         tx_done
);
  localparam int      BAUD_DIV = CLK_FRQ / BAUD_RATE;
  localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);
  localparam int      BIT_W    = $clog2(frame_len(DATA_BITS, PARITY, STOP_BITS) + 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $fatal(1, "uart_tx_cfg: BAUD_DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $fatal(1, "uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $fatal(1, "uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $fatal(1, "uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  tx_state_e            state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 tick;
  logic                 load;

  // Counter sits at zero while idle so the first start bit is a full period.
  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk      (clk),
    .areset_n (areset_n),
    .restart  (state_q == IDLE),
    .tick     (tick)
  );

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    bit_cnt_d    = bit_cnt_q;
    load         = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        load   = hold_valid_q;
      end
      START: if (tick) begin
        state_d   = DATA;
        tx_d      = shift_q[0];
        bit_cnt_d = '0;
      end
      DATA: if (tick) begin
        if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
          bit_cnt_d = '0;
          if (PAR_MODE != PAR_NONE) begin
            state_d = PAR;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          shift_d   = shift_q >> 1;
          tx_d      = shift_d[0];
        end
      end
      PAR: if (tick) begin
        state_d   = STOP;
        tx_d      = 1'b1;
        bit_cnt_d = '0;
      end
      STOP: if (tick) begin
        if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
          done_d = 1'b1;
          if (hold_valid_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Drain and accept are mutually exclusive: accept needs an empty hold register.
    if (load) begin
      state_d      = START;
      tx_d         = 1'b0;
      busy_d       = 1'b1;
      shift_d      = hold_data_q;
      par_bit_d    = (^hold_data_q) ^ (PAR_MODE == PAR_ODD);
      hold_valid_d = 1'b0;
    end else if (s.in_valid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = s.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state_q      <= IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      bit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign s.in_ready = !hold_valid_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - bench for uart_tx_cfg across 8N1, 8E1, 8O1 and 7O2 builds
module tb_uart_tx_cfg;
  localparam int DIV = 10;
  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PM [4] = '{0, 2, 1, 1};
  localparam int SB [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic [3:0] vld = 4'b0;
  logic [8:0] dat [4];
  wire  [3:0] rdy, txo, busy, done;

  int         vectors = 0;
  int         errors = 0;
  logic [8:0] exp_w [$];

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

  assign if0.in_valid = vld[0];
  assign if0.in_data  = dat[0][7:0];
  assign rdy[0]       = if0.in_ready;
  assign if1.in_valid = vld[1];
  assign if1.in_data  = dat[1][7:0];
  assign rdy[1]       = if1.in_ready;
  assign if2.in_valid = vld[2];
  assign if2.in_data  = dat[2][7:0];
  assign rdy[2]       = if2.in_ready;
  assign if3.in_valid = vld[3];
  assign if3.in_data  = dat[3][6:0];
  assign rdy[3]       = if3.in_ready;

  uart_tx_cfg #(.CLK_FRQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .areset_n(areset_n), .s(if0.slave), .tx(txo[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_cfg #(.CLK_FRQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .areset_n(areset_n), .s(if1.slave), .tx(txo[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_cfg #(.CLK_FRQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .areset_n(areset_n), .s(if2.slave), .tx(txo[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_cfg #(.CLK_FRQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut3 (
    .clk(clk), .areset_n(areset_n), .s(if3.slave), .tx(txo[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  function automatic int flen(input int d);
    return DIV * (1 + DB[d] + ((PM[d] != 0) ? 1 : 0) + SB[d]);
  endfunction

  // Line level for bit period pos of a frame carrying w.
  function automatic logic bit_at(input int d, input logic [8:0] w, input int pos);
    int ones = 0;
    for (int i = 0; i < DB[d]; i++) ones += int'(w[i]);
    if (pos == 0) return 1'b0;
    if (pos <= DB[d]) return w[pos-1];
    if (PM[d] != 0 && pos == DB[d] + 1) return (PM[d] == 2) ? ones[0] : !ones[0];
    return 1'b1;
  endfunction

  // {tx, busy, done} expected c cycles after the first frame edge, for nf queued frames.
  function automatic logic [2:0] exp_line(input int d, input int c, input int nf);
    int len = flen(d);
    logic [2:0] e;
    e[2] = (c < nf * len) ? bit_at(d, exp_w[c / len], (c % len) / DIV) : 1'b1;
    e[1] = (c < nf * len);
    e[0] = (c > 0) && (c % len == 0);
    return e;
  endfunction

  task automatic test_reset();
    areset_n = 1'b0;
    vld = 4'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if ({txo[d], busy[d], done[d], rdy[d]} !== 4'b1001) begin
        errors++;
        $display("FAIL reset dut%0d got=%b want=1001", d, {txo[d], busy[d], done[d], rdy[d]});
      end
    end
    areset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_frame(input int d, input logic [8:0] w, input string name);
    logic [2:0] e;
    exp_w.delete();
    exp_w.push_back(w);
    @(negedge clk);
    vld[d] = 1'b1;
    dat[d] = w;
    vectors++;
    if (rdy[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before got=%b want=1", name, rdy[d]);
    end
    @(negedge clk);
    vld[d] = 1'b0;
    vectors++;
    if ({txo[d], busy[d], rdy[d]} !== 3'b100) begin
      errors++;
      $display("FAIL %s accepted got=%b want=100", name, {txo[d], busy[d], rdy[d]});
    end
    for (int c = 0; c <= flen(d); c++) begin
      @(negedge clk);
      e = exp_line(d, c, 1);
      vectors++;
      if ({txo[d], busy[d], done[d]} !== e) begin
        errors++;
        $display("FAIL %s line c=%0d got=%b want=%b", name, c, {txo[d], busy[d], done[d]}, e);
      end
    end
    @(negedge clk);
    vectors++;
    if ({txo[d], busy[d], done[d], rdy[d]} !== 4'b1001) begin
      errors++;
      $display("FAIL %s idle_after got=%b want=1001", name, {txo[d], busy[d], done[d], rdy[d]});
    end
  endtask

  task automatic test_back_to_back(input int d, input logic [8:0] w0, input logic [8:0] w1);
    logic [2:0] e;
    exp_w.delete();
    exp_w.push_back(w0);
    exp_w.push_back(w1);
    @(negedge clk);
    vld[d] = 1'b1;
    dat[d] = w0;
    @(negedge clk);
    dat[d] = w1;
    vectors++;
    if (rdy[d] !== 1'b0) begin
      errors++;
      $display("FAIL b2b%0d ready_full got=%b want=0", d, rdy[d]);
    end
    fork
      begin
        @(negedge clk);
        vectors++;
        if (rdy[d] !== 1'b1) begin
          errors++;
          $display("FAIL b2b%0d ready_drained got=%b want=1", d, rdy[d]);
        end
        @(negedge clk);
        vld[d] = 1'b0;
        vectors++;
        if (rdy[d] !== 1'b0) begin
          errors++;
          $display("FAIL b2b%0d ready_second got=%b want=0", d, rdy[d]);
        end
      end
      begin
        for (int c = 0; c <= 2 * flen(d); c++) begin
          @(negedge clk);
          e = exp_line(d, c, 2);
          vectors++;
          if ({txo[d], busy[d], done[d]} !== e) begin
            errors++;
            $display("FAIL b2b%0d line c=%0d got=%b want=%b", d, c, {txo[d], busy[d], done[d]}, e);
          end
        end
      end
    join
  endtask

  task automatic test_ignore_data(input int d);
    logic [2:0] e;
    logic [8:0] w0, w1;
    w0 = 9'($urandom);
    w1 = 9'($urandom);
    exp_w.delete();
    exp_w.push_back(w0);
    exp_w.push_back(w1);
    @(negedge clk);
    vld[d] = 1'b1;
    dat[d] = w0;
    @(negedge clk);
    vld[d] = 1'b0;
    fork
      begin
        repeat (30) @(negedge clk);
        vld[d] = 1'b1;
        dat[d] = w1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
          dat[d] = 9'($urandom);
          vectors++;
          if (rdy[d] !== 1'b0) begin
            errors++;
            $display("FAIL ignore ready_low i=%0d got=%b want=0", i, rdy[d]);
          end
          @(negedge clk);
        end
        vld[d] = 1'b0;
      end
      begin
        for (int c = 0; c <= 2 * flen(d); c++) begin
          @(negedge clk);
          e = exp_line(d, c, 2);
          vectors++;
          if ({txo[d], busy[d], done[d]} !== e) begin
            errors++;
            $display("FAIL ignore line c=%0d got=%b want=%b", c, {txo[d], busy[d], done[d]}, e);
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] w;
    w = 9'($urandom);
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = w;
    @(negedge clk);
    dat[0] = 9'($urandom);
    @(negedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    vectors++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid pending got=%b want=0", rdy[0]);
    end
    repeat (42) @(negedge clk);
    vectors++;
    if (txo[0] !== bit_at(0, w, 4)) begin
      errors++;
      $display("FAIL rstmid bit3 got=%b want=%b", txo[0], bit_at(0, w, 4));
    end
    areset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({txo[0], busy[0], done[0], rdy[0]} !== 4'b1001) begin
      errors++;
      $display("FAIL rstmid after_reset got=%b want=1001", {txo[0], busy[0], done[0], rdy[0]});
    end
    areset_n = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      vectors++;
      if ({txo[0], busy[0], done[0]} !== 3'b100) begin
        errors++;
        $display("FAIL rstmid quiet c=%0d got=%b want=100", c, {txo[0], busy[0], done[0]});
      end
    end
    test_frame(0, 9'h03C, "rstmid_3c");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = '0;
    test_reset();
    test_frame(0, 9'h0A5, "8n1_a5");
    test_frame(1, 9'h007, "8e1_07");
    test_frame(2, 9'h007, "8o1_07");
    test_frame(3, 9'h07F, "7o2_7f");
    for (int d = 0; d < 4; d++) begin
      repeat (2) test_frame(d, 9'($urandom), "random");
    end
    test_back_to_back(0, 9'h055, 9'h0AA);
    test_back_to_back(3, 9'($urandom), 9'($urandom));
    test_ignore_data(0);
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
